bundler_stream_hf: RTL and testbench

- Streaming majority-vote bundler for the HDC seizure-detection datapath.
- Accumulates a bundle of NUM_HVS hypervectors delivered LANES per cycle into per-dimension saturating-free counters. Emits the thresholded bundled hypervector with a one-cycle `out` pulse.
- Generalises the single-shot bundler: arbitrary bundle size, multi-lane input, configurable even-count tie-break, abort (`clr`) and back-to-back bundles with no dead cycle.

---
 rtl/bundler_stream_hf_pkg.sv | 16 +
 rtl/bundler_stream_hf_if.sv | 21 ++
 rtl/bundler_dim_cnt.sv | 71 +++++++
 rtl/bundler_stream_hf.sv | 102 ++++++++++
 tb/tb_bundler_stream_hf.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bundler_stream_hf_pkg.sv
// Shared definitions for the streaming majority-vote bundler.
//   tie_mode_e : result selection on an exact vote tie (even bundle sizes)
//   cnt_width  : bits needed to hold a count in 0..n (at least 1)
package bundler_stream_hf_pkg;

  typedef enum int unsigned {
    TIE_ZERO  = 0,
    TIE_ONE   = 1,
    TIE_FIRST = 2
  } tie_mode_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bundler_stream_hf_if.sv
// Beat/result bundle between a hypervector source and the bundler.
//   en     : beat valid, hv_in consumed every cycle it is high
//   clr    : abort the partial bundle
//   hv_in  : LANES hypervectors of DIMENSIONS bits for this beat
//   busy   : a partial bundle is held
//   out    : one-cycle pulse, hv_out is new
//   hv_out : bundled hypervector, held until the next result
interface bundler_stream_hf_if #(
  parameter int unsigned DIMENSIONS = 10000,
  parameter int unsigned LANES      = 1
);
  logic                                en;
  logic                                clr;
  logic [LANES-1:0][DIMENSIONS-1:0]    hv_in;
  logic                                busy;
  logic                                out;
  logic [DIMENSIONS-1:0]               hv_out;

  modport master (output en, clr, hv_in, input busy, out, hv_out);
  modport slave  (input en, clr, hv_in, output busy, out, hv_out);
endinterface

// File: rtl/bundler_dim_cnt.sv
// One dimension of the bundler: popcount of this dimension across the lanes
// of a beat, running vote counter and majority threshold on the final beat.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : drop the partial count (result bit untouched)
//   en         : beat valid
//   final_beat : this beat completes the bundle
//   lane_bits  : this dimension's bit from every lane
//   tie_bit    : bit of the bundle's first hypervector (used on a tie)
//   hv_bit     : registered majority result
module bundler_dim_cnt
  import bundler_stream_hf_pkg::*;
#(
  parameter int unsigned NUM_HVS  = 5,
  parameter int unsigned LANES    = 1,
  parameter int unsigned TIE_MODE = 2,
  parameter int unsigned CW       = cnt_width(NUM_HVS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             final_beat,
  input  logic [LANES-1:0] lane_bits,
  input  logic             tie_bit,
  output logic             hv_bit
);

  localparam logic [CW:0] THRESH = (CW+1)'(NUM_HVS);

  logic [CW-1:0] cnt;
  logic [CW-1:0] ones;
  logic [CW-1:0] sum;
  logic [CW:0]   twice;
  logic          maj;

  always_comb begin
    ones = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      ones = ones + CW'(lane_bits[l]);
    end
    sum   = cnt + ones;
    twice = {sum, 1'b0};
    maj   = 1'b0;
    if (twice > THRESH) begin
      maj = 1'b1;
    end else if (twice == THRESH) begin
      if (TIE_MODE == TIE_ONE) begin
        maj = 1'b1;
      end else if (TIE_MODE == TIE_FIRST) begin
        maj = tie_bit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      hv_bit <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (final_beat) begin
        cnt    <= '0;
        hv_bit <= maj;
      end else begin
        cnt <= sum;
      end
    end
  end

endmodule

// File: rtl/bundler_stream_hf.sv
// Streaming majority-vote bundler. Accumulates NUM_HVS hypervectors delivered
// LANES per beat and emits the thresholded bundle with a one-cycle out pulse.
// Back-to-back bundles need no idle cycle; clr aborts a partial bundle.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : slave side of bundler_stream_hf_if (en, clr, hv_in, busy, out, hv_out)
module bundler_stream_hf
  import bundler_stream_hf_pkg::*;
#(
  parameter int unsigned DIMENSIONS = 10000,
  parameter int unsigned NUM_HVS    = 5,
  parameter int unsigned LANES      = 1,
  parameter int unsigned TIE_MODE   = 2
) (
  input logic               clk,
  input logic               rst,
  bundler_stream_hf_if.slave bus
);

  localparam int unsigned BEATS       = NUM_HVS / LANES;
  localparam int unsigned BW          = cnt_width(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam bit USE_TIE_REG = (TIE_MODE == TIE_FIRST) && ((NUM_HVS % 2) == 0);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  logic [0:0]            state;
  logic [BW-1:0]         beat_cnt;
  logic                  out_q;
  logic                  final_beat;
  logic [DIMENSIONS-1:0] tie_src;
  logic [DIMENSIONS-1:0] hv_bits;

  assign final_beat = (beat_cnt == LAST_BEAT);

  // state tracks beat_cnt != 0; with BEATS=1 beat 0 is already final so
  // the FSM never leaves IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      out_q    <= 1'b0;
    end else begin
      out_q <= bus.en && !bus.clr && final_beat;
      if (bus.clr) begin
        state    <= ST_IDLE;
        beat_cnt <= '0;
      end else if (bus.en) begin
        if (final_beat) begin
          state    <= ST_IDLE;
          beat_cnt <= '0;
        end else begin
          state    <= ST_ACCUM;
          beat_cnt <= beat_cnt + BW'(1);
        end
      end
    end
  end

  // On beat 0 the tie source is the live lane 0, so a single-beat bundle
  // still sees its first hypervector.
  if (USE_TIE_REG) begin : g_tie
    logic [DIMENSIONS-1:0] tie_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        tie_q <= '0;
      end else if (bus.en && !bus.clr && (beat_cnt == '0)) begin
        tie_q <= bus.hv_in[0];
      end
    end
    assign tie_src = (beat_cnt == '0) ? bus.hv_in[0] : tie_q;
  end else begin : g_no_tie
    assign tie_src = '0;
  end

  for (genvar d = 0; d < DIMENSIONS; d++) begin : g_dim
    logic [LANES-1:0] lane_bits;
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign lane_bits[l] = bus.hv_in[l][d];
    end
    bundler_dim_cnt #(
      .NUM_HVS  (NUM_HVS),
      .LANES    (LANES),
      .TIE_MODE (TIE_MODE)
    ) u_dim (
      .clk        (clk),
      .rst        (rst),
      .clr        (bus.clr),
      .en         (bus.en),
      .final_beat (final_beat),
      .lane_bits  (lane_bits),
      .tie_bit    (tie_src[d]),
      .hv_bit     (hv_bits[d])
    );
  end

  assign bus.busy   = (state == ST_ACCUM);
  assign bus.out    = out_q;
  assign bus.hv_out = hv_bits;

endmodule

// File: tb/tb_bundler_stream_hf.sv
// Bench for bundler_stream_hf: D=5/N=5/L=1 table-driven stream with a timed
// scoreboard, D=4/N=4/L=2 tie modes, reset and abort sequences, and a
// randomised D=64/N=12/L=3 run against a majority reference for all tie modes.
module tb_bundler_stream_hf;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- DUT A: D=5, NUM_HVS=5, LANES=1, TIE_FIRST ----------------
  bundler_stream_hf_if #(.DIMENSIONS(5), .LANES(1)) ifa ();
  bundler_stream_hf #(.DIMENSIONS(5), .NUM_HVS(5), .LANES(1), .TIE_MODE(2)) u_a (
    .clk (clk), .rst (rst), .bus (ifa)
  );

  typedef struct {
    logic       en;
    logic       clr;
    logic [4:0] hv;
    logic       busy;
    logic       push;
    logic [4:0] exp;
  } vec_t;

  typedef struct {
    logic [4:0] hv;
    int         due;
  } exp_t;

  vec_t tbl[$];
  exp_t qa[$];

  function automatic vec_t mk(input logic en, input logic clr, input logic [4:0] hv,
                              input logic busy, input logic push, input logic [4:0] exp);
    vec_t v;
    v.en = en; v.clr = clr; v.hv = hv; v.busy = busy; v.push = push; v.exp = exp;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    ifa.en    = v.en;
    ifa.clr   = v.clr;
    ifa.hv_in = v.hv;
    if (v.push) qa.push_back('{hv: v.exp, due: cyc + 1});
    tick();
    check($sformatf("A busy row %0d", idx), ifa.busy, v.busy);
  endtask

  initial begin : mon_a
    logic exp_o;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      exp_o = (qa.size() != 0) && (qa[0].due == cyc);
      check($sformatf("A out cyc %0d", cyc), ifa.out, exp_o);
      if (exp_o) begin
        e = qa.pop_front();
        check($sformatf("A hv_out cyc %0d", cyc), ifa.hv_out, e.hv);
      end
    end
  end

  // ---------------- Tie DUTs: D=4, NUM_HVS=4, LANES=2, modes 0/1/2 ----------------
  logic            t_en = 1'b0;
  logic [1:0][3:0] t_hv = '0;
  bundler_stream_hf_if #(.DIMENSIONS(4), .LANES(2)) ift0 ();
  bundler_stream_hf_if #(.DIMENSIONS(4), .LANES(2)) ift1 ();
  bundler_stream_hf_if #(.DIMENSIONS(4), .LANES(2)) ift2 ();
  assign ift0.en = t_en; assign ift0.clr = 1'b0; assign ift0.hv_in = t_hv;
  assign ift1.en = t_en; assign ift1.clr = 1'b0; assign ift1.hv_in = t_hv;
  assign ift2.en = t_en; assign ift2.clr = 1'b0; assign ift2.hv_in = t_hv;
  bundler_stream_hf #(.DIMENSIONS(4), .NUM_HVS(4), .LANES(2), .TIE_MODE(0)) u_t0 (
    .clk (clk), .rst (rst), .bus (ift0)
  );
  bundler_stream_hf #(.DIMENSIONS(4), .NUM_HVS(4), .LANES(2), .TIE_MODE(1)) u_t1 (
    .clk (clk), .rst (rst), .bus (ift1)
  );
  bundler_stream_hf #(.DIMENSIONS(4), .NUM_HVS(4), .LANES(2), .TIE_MODE(2)) u_t2 (
    .clk (clk), .rst (rst), .bus (ift2)
  );

  // ---------------- Random DUTs: D=64, NUM_HVS=12, LANES=3, modes 0/1/2 ----------------
  logic             r_en = 1'b0;
  logic             r_clr = 1'b0;
  logic [2:0][63:0] r_hv = '0;

  for (genvar g = 0; g < 3; g++) begin : g_rand
    bundler_stream_hf_if #(.DIMENSIONS(64), .LANES(3)) bus ();
    assign bus.en = r_en; assign bus.clr = r_clr; assign bus.hv_in = r_hv;
    bundler_stream_hf #(.DIMENSIONS(64), .NUM_HVS(12), .LANES(3), .TIE_MODE(g)) u_dut (
      .clk (clk), .rst (rst), .bus (bus)
    );

    int n_out = 0;
    int n_bund = 0;

    initial begin : model
      int          cnt [64];
      int          beat;
      logic [63:0] first;
      logic [63:0] e;
      logic [63:0] q[$];
      logic        exp_o;
      beat = 0;
      first = '0;
      foreach (cnt[d]) cnt[d] = 0;
      forever begin
        @(posedge clk);
        if (rst || r_clr) begin
          foreach (cnt[d]) cnt[d] = 0;
          beat = 0;
          if (rst) q.delete();
        end else if (r_en) begin
          if (beat == 0) first = r_hv[0];
          for (int d = 0; d < 64; d++)
            for (int l = 0; l < 3; l++) cnt[d] += int'(r_hv[l][d]);
          beat++;
          if (beat == 4) begin
            for (int d = 0; d < 64; d++) begin
              if (2 * cnt[d] > 12)      e[d] = 1'b1;
              else if (2 * cnt[d] < 12) e[d] = 1'b0;
              else e[d] = (g == 0) ? 1'b0 : (g == 1) ? 1'b1 : first[d];
              cnt[d] = 0;
            end
            beat = 0;
            q.push_back(e);
            n_bund++;
          end
        end
        #1;
        exp_o = (q.size() != 0);
        if (bus.out) n_out++;
        check($sformatf("R m%0d out cyc %0d", g, cyc), bus.out, exp_o);
        if (exp_o) check($sformatf("R m%0d hv_out cyc %0d", g, cyc), bus.hv_out, q.pop_front());
      end
    end
  end

  // ---------------- Main sequence ----------------
  initial begin
    ifa.en = 1'b0; ifa.clr = 1'b0; ifa.hv_in = '0;

    // Scenario 1
    tbl.push_back(mk(1, 0, 5'b01101, 1, 0, '0));
    tbl.push_back(mk(1, 0, 5'b00111, 1, 0, '0));
    tbl.push_back(mk(1, 0, 5'b01111, 1, 0, '0));
    tbl.push_back(mk(1, 0, 5'b00011, 1, 0, '0));
    tbl.push_back(mk(1, 0, 5'b00011, 0, 1, 5'b00111));
    tbl.push_back(mk(0, 0, 5'b00000, 0, 0, '0));
    tbl.push_back(mk(1, 0, 5'b00010, 1, 0, '0));
    tbl.push_back(mk(1, 0, 5'b10000, 1, 0, '0));
    tbl.push_back(mk(1, 0, 5'b01000, 1, 0, '0));
    tbl.push_back(mk(1, 0, 5'b10100, 1, 0, '0));
    tbl.push_back(mk(1, 0, 5'b00100, 0, 1, 5'b00000));
    tbl.push_back(mk(0, 0, 5'b00000, 0, 0, '0));
    // Scenario 2: back-to-back, outs 5 cycles apart
    tbl.push_back(mk(1, 0, 5'b11011, 1, 0, '0));
    tbl.push_back(mk(1, 0, 5'b11011, 1, 0, '0));
    tbl.push_back(mk(1, 0, 5'b01111, 1, 0, '0));
    tbl.push_back(mk(1, 0, 5'b10111, 1, 0, '0));
    tbl.push_back(mk(1, 0, 5'b10101, 0, 1, 5'b11111));
    tbl.push_back(mk(1, 0, 5'b01101, 1, 0, '0));
    tbl.push_back(mk(1, 0, 5'b00111, 1, 0, '0));
    tbl.push_back(mk(1, 0, 5'b01111, 1, 0, '0));
    tbl.push_back(mk(1, 0, 5'b00011, 1, 0, '0));
    tbl.push_back(mk(1, 0, 5'b00011, 0, 1, 5'b00111));
    tbl.push_back(mk(0, 0, 5'b00000, 0, 0, '0));
    // Scenario 4: gap then clr; clr+en discards the beat; clean bundle after
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 5'b11111, 1, 0, '0));
    for (int i = 0; i < 7; i++) tbl.push_back(mk(0, 0, 5'b00000, 1, 0, '0));
    tbl.push_back(mk(0, 1, 5'b00000, 0, 0, '0));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(1, 0, 5'b11111, 1, 0, '0));
    tbl.push_back(mk(1, 1, 5'b11111, 0, 0, '0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 0, 5'b00000, 1, 0, '0));
    tbl.push_back(mk(1, 0, 5'b00000, 0, 1, 5'b00000));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 0, 5'b11011, 1, 0, '0));
    tbl.push_back(mk(1, 0, 5'b11011, 0, 1, 5'b11011));
    tbl.push_back(mk(0, 0, 5'b00000, 0, 0, '0));

    // Reset state
    repeat (3) tick();
    check("rst A busy", ifa.busy, 1'b0);
    check("rst A out", ifa.out, 1'b0);
    check("rst A hv_out", ifa.hv_out, '0);
    check("rst T2 hv_out", ift2.hv_out, '0);
    check("rst R0 busy", g_rand[0].bus.busy, 1'b0);
    rst = 1'b0;

    foreach (tbl[i]) apply(tbl[i], i);

    // Scenario 5: reset mid-bundle with en high; hv_out currently 11011
    apply(mk(1, 0, 5'b11111, 1, 0, '0), 100);
    apply(mk(1, 0, 5'b11111, 1, 0, '0), 101);
    rst = 1'b1;
    ifa.en = 1'b1; ifa.hv_in = 5'b11111;
    tick();
    check("mid rst A hv_out", ifa.hv_out, '0);
    check("mid rst A out", ifa.out, 1'b0);
    check("mid rst A busy", ifa.busy, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) apply(tbl[i], 200 + i);
    apply(mk(0, 0, 5'b00000, 0, 0, '0), 205);

    // Scenario 3: every dimension ties
    t_en = 1'b1;
    t_hv[0] = 4'b1100; t_hv[1] = 4'b1010;
    tick();
    check("T3 beat1 out", {ift0.out, ift1.out, ift2.out}, 3'b000);
    check("T3 beat1 busy", {ift0.busy, ift1.busy, ift2.busy}, 3'b111);
    t_hv[0] = 4'b0011; t_hv[1] = 4'b0101;
    tick();
    check("T3 out", {ift0.out, ift1.out, ift2.out}, 3'b111);
    check("T3 m0 hv_out", ift0.hv_out, 4'b0000);
    check("T3 m1 hv_out", ift1.hv_out, 4'b1111);
    check("T3 m2 hv_out", ift2.hv_out, 4'b1100);
    t_en = 1'b0;
    tick();
    check("T3 pulse end", {ift0.out, ift1.out, ift2.out}, 3'b000);
    check("T3 m2 hold", ift2.hv_out, 4'b1100);

    // Scenario 6: randomised stream
    for (int i = 0; i < 400; i++) begin
      r_en  = ($urandom_range(0, 9) < 8);
      r_clr = ($urandom_range(0, 29) == 0);
      for (int l = 0; l < 3; l++) r_hv[l] = {$urandom, $urandom};
      tick();
    end
    r_en = 1'b0; r_clr = 1'b0;
    repeat (3) tick();
    check("R m0 out count", g_rand[0].n_out, g_rand[0].n_bund);
    check("R m1 out count", g_rand[1].n_out, g_rand[1].n_bund);
    check("R m2 out count", g_rand[2].n_out, g_rand[2].n_bund);
    check("R enough bundles", (g_rand[0].n_bund >= 20), 1'b1);
    check("A queue drained", qa.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
